// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the two-stage ALU and its issuer.
//   operation_t  - ALU operation encoding (2'h3 is reserved and yields 0)
//   ALU_LATENCY  - cycles from ALU input capture to registered result
//   alu_ref()    - reference arithmetic, modulo the caller's width
package alu_pkg;

  typedef enum logic [1:0] {
    nop = 2'h0,
    add = 2'h1,
    sub = 2'h2
  } operation_t;

  localparam int unsigned ALU_LATENCY = 2;
  localparam int unsigned ALU_REF_W   = 32;

  // Computed at ALU_REF_W bits; callers truncate to their own width, which
  // gives the same result as doing the arithmetic modulo 2^WIDTH.
  function automatic logic [ALU_REF_W-1:0] alu_ref(operation_t op,
                                                   logic [ALU_REF_W-1:0] a,
                                                   logic [ALU_REF_W-1:0] b);
    case (op)
      add:     return a + b;
      sub:     return a + (~b + 1'b1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO holding ALU responses.
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write one entry (also accepted when full if pop is high)
//   pop             - remove head entry (ignored when empty)
//   head_data       - current head entry, combinational
//   count           - occupancy, $clog2(DEPTH)+1 bits
//   empty, full     - occupancy flags
module alu_rsp_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: credit-based initiator for the registered two-stage ALU.
// Commands are issued only when response-buffer space is reserved, so every
// ALU result has a FIFO slot; results return in order on rsp_*.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b - command stream in
//   alu_op/alu_a/alu_b/alu_in_valid        - registered ALU inputs
//   alu_out/alu_out_valid                  - ALU result
//   rsp_valid/rsp_ready/rsp_data           - response stream out
//   rsp_mismatch   - head result differed from the expected value
//   busy           - anything in flight or buffered
//   err_unexpected - sticky: ALU result arrived with nothing in flight
// Build option: define ALU_ISSUER_CHECK_EN to add the shadow checker;
// without it rsp_mismatch is tied low and the FIFO stores data only.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  operation_t       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output operation_t       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_mismatch,
  output logic             busy,
  output logic             err_unexpected
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUER_CHECK_EN
  localparam int unsigned FW = WIDTH + 1;
`else
  localparam int unsigned FW = WIDTH;
`endif

  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] credits;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head_data;

  assign credits   = CW'(DEPTH) - fifo_count - inflight;
  assign cmd_ready = (credits != '0);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = alu_out_valid && (inflight != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign busy      = (inflight != '0) || (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op         <= nop;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_in_valid   <= 1'b0;
      inflight       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      alu_in_valid <= accept;
      if (accept) begin
        alu_op <= cmd_op;
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
      end
      inflight <= inflight + CW'(accept) - CW'(push);
      if (alu_out_valid && (inflight == '0)) err_unexpected <= 1'b1;
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  // Shadow pipeline fed from the registered ALU inputs, so its last stage
  // lines up with alu_out for the same command.
  logic [WIDTH-1:0] shadow [ALU_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ALU_LATENCY; i++) shadow[i] <= '0;
    end else begin
      shadow[0] <= WIDTH'(alu_ref(alu_op, ALU_REF_W'(alu_a), ALU_REF_W'(alu_b)));
      for (int unsigned i = 1; i < ALU_LATENCY; i++) shadow[i] <= shadow[i-1];
    end
  end

  assign push_data    = {(alu_out != shadow[ALU_LATENCY-1]), alu_out};
  assign rsp_mismatch = !fifo_empty && head_data[WIDTH];
`else
  assign push_data    = alu_out;
  assign rsp_mismatch = 1'b0;
`endif

  // Head data is gated so the response bus reads zero when nothing is held.
  assign rsp_data = fifo_empty ? '0 : head_data[WIDTH-1:0];

  alu_rsp_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Credit reservation means a push into a full FIFO always coincides with a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && fifo_full) |-> pop);

endmodule
